m_ext_seq: RTL and testbench



---
 rtl/m_ext_pkg.sv | 44 ++++
 rtl/m_ext_neg.sv | 23 ++
 rtl/m_ext_seq.sv | 184 ++++++++++++++++++
 tb/tb_m_ext_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/m_ext_pkg.sv
// ============================================================================
// Module   : m_ext_pkg
// Brief    : Shared encodings, constants and decode helpers for m_ext_seq.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package m_ext_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_ext_neg.sv
// ============================================================================
// Module   : m_ext_neg
// Brief    : Conditional two's-complement negate of a WIDTH-bit word.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module m_ext_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  assign o_data = i_en ? (~i_data + c_one) : i_data;

endmodule

`default_nettype wire

// File: rtl/m_ext_seq.sv
// ============================================================================
// Module   : m_ext_seq
// Brief    : Sequenced RV32M unit: 32-cycle shift-add multiply and restoring
//            divide on magnitudes, sign fix-up in a final cycle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module m_ext_seq
  import m_ext_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             ip_clk,
  input  logic             ip_rst_n,
  input  logic             ip_flush,
  input  logic             ip_valid,
  output logic             op_ready,
  input  logic [31:0]      ip_rs1,
  input  logic [31:0]      ip_rs2,
  input  logic [2:0]       ip_funct_3,
  input  logic [TAG_W-1:0] ip_tag,
  output logic             op_valid,
  input  logic             ip_ready,
  output logic [31:0]      op_result,
  output logic             op_overflow,
  output logic [TAG_W-1:0] op_tag,
  output logic             op_busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_f3;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_neg;
  logic [63:0]      r_acc;
  logic [4:0]       r_cnt;
  logic [31:0]      r_result;
  logic             r_overflow;
  logic             r_valid;

  // Operand magnitudes and special-case decode, valid only on the accept cycle
  logic        w_rs1_neg_en;
  logic        w_rs2_neg_en;
  logic [31:0] w_rs1_abs;
  logic [31:0] w_rs2_abs;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_special;
  logic        w_neg_flag;
  logic [31:0] w_special_result;

  assign w_rs1_neg_en = rs1_signed(ip_funct_3) & ip_rs1[31];
  assign w_rs2_neg_en = rs2_signed(ip_funct_3) & ip_rs2[31];

  m_ext_neg #(.WIDTH(32)) u_abs_rs1 (.i_data(ip_rs1), .i_en(w_rs1_neg_en), .o_data(w_rs1_abs));
  m_ext_neg #(.WIDTH(32)) u_abs_rs2 (.i_data(ip_rs2), .i_en(w_rs2_neg_en), .o_data(w_rs2_abs));

  assign w_div_zero = is_div(ip_funct_3) & (ip_rs2 == 32'd0);
  assign w_div_ovf  = ((ip_funct_3 == F3_DIV) || (ip_funct_3 == F3_REM)) &
                      (ip_rs1 == INT_MIN) & (ip_rs2 == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero | w_div_ovf;

  // REM takes the dividend's sign; DIV and multiplies take the XOR of both
  assign w_neg_flag = (ip_funct_3 == F3_REM) ? w_rs1_neg_en : (w_rs1_neg_en ^ w_rs2_neg_en);

  always_comb begin
    w_special_result = 32'd0;
    if (w_div_zero) begin
      w_special_result = ip_funct_3[1] ? ip_rs1 : DIV_ZERO_Q;
    end else if (w_div_ovf) begin
      w_special_result = ip_funct_3[1] ? 32'd0 : INT_MIN;
    end
  end

  // Iteration datapath: r_acc[63:32] is product-high / partial remainder
  logic [32:0] w_mul_sum;
  logic [32:0] w_prem;
  logic [32:0] w_diff;
  logic        w_ge;

  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_a[0] ? {1'b0, r_b} : 33'd0);
  assign w_prem    = {r_acc[63:32], r_a[31]};
  assign w_diff    = w_prem - {1'b0, r_b};
  assign w_ge      = ~w_diff[32];

  // Fix-up: negate the full 64-bit value so MULH* high words come out right
  logic [63:0] w_fix_src;
  logic [63:0] w_fix_neg;
  logic [31:0] w_fix_word;

  assign w_fix_src = is_div(r_f3) ? (r_f3[1] ? {32'd0, r_acc[63:32]} : {32'd0, r_a}) : r_acc;

  m_ext_neg #(.WIDTH(64)) u_neg_fix (.i_data(w_fix_src), .i_en(r_neg), .o_data(w_fix_neg));

  assign w_fix_word = ((r_f3 == F3_MUL) || is_div(r_f3)) ? w_fix_neg[31:0] : w_fix_neg[63:32];

  always_comb begin
    w_state_next = r_state;
    if (ip_flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (ip_valid) w_state_next = w_special ? ST_DONE : ST_CALC;
        ST_CALC: if (r_cnt == 5'd31) w_state_next = ST_FIX;
        ST_FIX:  w_state_next = ST_DONE;
        ST_DONE: if (ip_ready) w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      r_state    <= ST_IDLE;
      r_f3       <= 3'd0;
      r_tag      <= '0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_neg      <= 1'b0;
      r_acc      <= 64'd0;
      r_cnt      <= 5'd0;
      r_result   <= 32'd0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (ip_flush) begin
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (ip_valid) begin
              r_f3  <= ip_funct_3;
              r_tag <= ip_tag;
              r_a   <= w_rs1_abs;
              r_b   <= w_rs2_abs;
              r_neg <= w_neg_flag;
              r_acc <= 64'd0;
              r_cnt <= 5'd0;
              if (w_special) begin
                r_result   <= w_special_result;
                r_overflow <= 1'b1;
                r_valid    <= 1'b1;
              end
            end
          end
          ST_CALC: begin
            r_cnt <= r_cnt + 5'd1;
            if (is_div(r_f3)) begin
              r_acc[63:32] <= w_ge ? w_diff[31:0] : w_prem[31:0];
              r_a          <= {r_a[30:0], w_ge};
            end else begin
              r_acc <= {w_mul_sum, r_acc[31:1]};
              r_a   <= {1'b0, r_a[31:1]};
            end
          end
          ST_FIX: begin
            r_result   <= w_fix_word;
            r_overflow <= 1'b0;
            r_valid    <= 1'b1;
          end
          ST_DONE: begin
            if (ip_ready) r_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign op_ready    = (r_state == ST_IDLE);
  assign op_busy     = (r_state == ST_CALC) || (r_state == ST_FIX);
  assign op_valid    = r_valid;
  assign op_result   = r_result;
  assign op_overflow = r_overflow;
  assign op_tag      = r_tag;

endmodule

`default_nettype wire

// File: tb/tb_m_ext_seq.sv
// ============================================================================
// Module   : tb_m_ext_seq
// Brief    : Directed self-checking bench for m_ext_seq.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_m_ext_seq;

  localparam int TAG_W = 5;

  logic             ip_clk = 1'b0;
  logic             ip_rst_n;
  logic             ip_flush;
  logic             ip_valid;
  logic             op_ready;
  logic [31:0]      ip_rs1;
  logic [31:0]      ip_rs2;
  logic [2:0]       ip_funct_3;
  logic [TAG_W-1:0] ip_tag;
  logic             op_valid;
  logic             ip_ready;
  logic [31:0]      op_result;
  logic             op_overflow;
  logic [TAG_W-1:0] op_tag;
  logic             op_busy;

  int n_checks = 0;
  int n_fail   = 0;

  m_ext_seq #(.TAG_W(TAG_W)) dut (
    .ip_clk      (ip_clk),
    .ip_rst_n    (ip_rst_n),
    .ip_flush    (ip_flush),
    .ip_valid    (ip_valid),
    .op_ready    (op_ready),
    .ip_rs1      (ip_rs1),
    .ip_rs2      (ip_rs2),
    .ip_funct_3  (ip_funct_3),
    .ip_tag      (ip_tag),
    .op_valid    (op_valid),
    .ip_ready    (ip_ready),
    .op_result   (op_result),
    .op_overflow (op_overflow),
    .op_tag      (op_tag),
    .op_busy     (op_busy)
  );

  always #5 ip_clk = ~ip_clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Waits for op_valid after an accept edge; returns edges elapsed (100 = timeout)
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!op_valid && lat < 100) begin
      @(posedge ip_clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input string name);
    @(negedge ip_clk); ip_ready = 1'b1;
    @(posedge ip_clk); #1;
    check({name, "_valid_drop"}, op_valid, 1'b0);
    check({name, "_ready_back"}, op_ready, 1'b1);
    ip_ready = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [2:0] f3,
                        input logic [4:0] tag, input logic [31:0] exp_res, input logic exp_ovf,
                        input int exp_lat, input string name);
    int lat;
    @(negedge ip_clk);
    ip_valid = 1'b1; ip_rs1 = rs1; ip_rs2 = rs2; ip_funct_3 = f3; ip_tag = tag;
    @(posedge ip_clk); #1;
    // Operands change right after the accept edge and must be ignored
    ip_valid = 1'b0; ip_rs1 = ~rs1; ip_rs2 = ~rs2; ip_tag = ~tag;
    wait_valid(lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, op_result, exp_res);
    check({name, "_overflow"}, op_overflow, exp_ovf);
    check({name, "_tag"}, op_tag, tag);
    consume(name);
  endtask

  initial begin
    int lat;
    logic seen;
    ip_rst_n = 1'b0; ip_flush = 1'b0; ip_valid = 1'b0; ip_ready = 1'b0;
    ip_rs1 = 32'd0; ip_rs2 = 32'd0; ip_funct_3 = 3'd0; ip_tag = '0;

    repeat (2) @(posedge ip_clk); #1;
    check("rst_ready", op_ready, 1'b1);
    check("rst_valid", op_valid, 1'b0);
    check("rst_busy", op_busy, 1'b0);
    check("rst_result", op_result, 32'd0);
    check("rst_overflow", op_overflow, 1'b0);
    check("rst_tag", op_tag, 5'd0);
    @(negedge ip_clk); ip_rst_n = 1'b1;

    run_op(32'd7, 32'hFFFF_FFFD, 3'b000, 5'd9, 32'hFFFF_FFEB, 1'b0, 33, "mul");
    run_op(32'h8000_0000, 32'h8000_0000, 3'b001, 5'd1, 32'h4000_0000, 1'b0, 33, "mulh");
    run_op(32'h8000_0000, 32'h8000_0000, 3'b010, 5'd2, 32'hC000_0000, 1'b0, 33, "mulhsu");
    run_op(32'h8000_0000, 32'h8000_0000, 3'b011, 5'd3, 32'h4000_0000, 1'b0, 33, "mulhu");
    run_op(32'hFFFF_FFF9, 32'd2, 3'b100, 5'd4, 32'hFFFF_FFFD, 1'b0, 33, "div");
    run_op(32'hFFFF_FFF9, 32'd2, 3'b110, 5'd5, 32'hFFFF_FFFF, 1'b0, 33, "rem");
    run_op(32'hFFFF_FFF9, 32'd2, 3'b101, 5'd6, 32'h7FFF_FFFC, 1'b0, 33, "divu");
    run_op(32'hFFFF_FFF9, 32'd2, 3'b111, 5'd7, 32'd1, 1'b0, 33, "remu");
    run_op(32'd5, 32'd0, 3'b100, 5'd10, 32'hFFFF_FFFF, 1'b1, 0, "div0");
    run_op(32'd5, 32'd0, 3'b110, 5'd11, 32'd5, 1'b1, 0, "rem0");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 5'd12, 32'h8000_0000, 1'b1, 0, "divovf");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 5'd13, 32'd0, 1'b1, 0, "removf");

    // Result held in DONE while a competing request waits
    @(negedge ip_clk);
    ip_valid = 1'b1; ip_rs1 = 32'd3; ip_rs2 = 32'd5; ip_funct_3 = 3'b000; ip_tag = 5'd3;
    @(posedge ip_clk); #1;
    ip_valid = 1'b0;
    wait_valid(lat);
    check("hold_latency", lat, 33);
    @(negedge ip_clk);
    ip_valid = 1'b1; ip_rs1 = 32'd100; ip_rs2 = 32'd7; ip_funct_3 = 3'b101; ip_tag = 5'd17;
    for (int i = 0; i < 10; i++) begin
      @(posedge ip_clk); #1;
      check("hold_result", op_result, 32'd15);
      check("hold_valid", op_valid, 1'b1);
      check("hold_ready", op_ready, 1'b0);
    end
    @(negedge ip_clk); ip_ready = 1'b1;
    @(posedge ip_clk); #1;
    check("hold_release_valid", op_valid, 1'b0);
    check("hold_release_ready", op_ready, 1'b1);
    ip_ready = 1'b0;
    @(posedge ip_clk); #1;
    check("next_accept_busy", op_busy, 1'b1);
    check("next_accept_ready", op_ready, 1'b0);
    ip_valid = 1'b0;
    wait_valid(lat);
    check("next_latency", lat, 33);
    check("next_result", op_result, 32'd14);
    check("next_tag", op_tag, 5'd17);
    consume("next");

    // Flush at CALC count 15
    @(negedge ip_clk);
    ip_valid = 1'b1; ip_rs1 = 32'd11; ip_rs2 = 32'd13; ip_funct_3 = 3'b000; ip_tag = 5'd21;
    @(posedge ip_clk); #1;
    ip_valid = 1'b0;
    repeat (15) @(posedge ip_clk);
    @(negedge ip_clk); ip_flush = 1'b1;
    @(posedge ip_clk); #1;
    ip_flush = 1'b0;
    check("flush_busy", op_busy, 1'b0);
    check("flush_ready", op_ready, 1'b1);
    check("flush_valid", op_valid, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge ip_clk); #1;
      seen = seen | op_valid;
    end
    check("flush_no_result", seen, 1'b0);

    // Asynchronous reset mid-CALC
    @(negedge ip_clk);
    ip_valid = 1'b1; ip_rs1 = 32'd9; ip_rs2 = 32'd4; ip_funct_3 = 3'b100; ip_tag = 5'd30;
    @(posedge ip_clk); #1;
    ip_valid = 1'b0;
    repeat (5) @(posedge ip_clk);
    #2; ip_rst_n = 1'b0;
    #1;
    check("arst_busy", op_busy, 1'b0);
    check("arst_ready", op_ready, 1'b1);
    check("arst_valid", op_valid, 1'b0);
    check("arst_result", op_result, 32'd0);
    check("arst_tag", op_tag, 5'd0);
    @(negedge ip_clk); ip_rst_n = 1'b1;

    run_op(32'h8000_0000, 32'd3, 3'b100, 5'd8, 32'hD555_5556, 1'b0, 33, "post_rst_div");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
